// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The master drives the controls and the slave (the counter) returns Q/TC/Ovf.
interface mod_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             Clear;
  logic             L;
  logic [WIDTH-1:0] R;
  logic             E;
  logic             Up;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             Ovf;

  modport master (output Clear, L, R, E, Up, input Q, TC, Ovf);
  modport slave  (input Clear, L, R, E, Up, output Q, TC, Ovf);
endinterface

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with parallel load, enable prescaler and wrap/saturate mode.
// Ovf is a registered boundary pulse intended to feed E of the next stage in a chain.
module mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 2**WIDTH-1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic               Clock,
  input  logic               Resetn,
  mod_updown_counter_if.slave bus
);
  localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE-1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             ovf_q, ovf_d;
  logic             at_bound;
  logic             step;

  // Boundary in the current direction; doubles as the combinational TC.
  assign at_bound = bus.Up ? (q_q == MAX_V) : (q_q == '0);

  always_comb begin
    q_d   = q_q;
    ps_d  = ps_q;
    ovf_d = 1'b0;
    step  = 1'b0;
    if (bus.Clear) begin
      q_d  = '0;
      ps_d = '0;
    end else if (bus.L) begin
      q_d  = (bus.R > MAX_V) ? MAX_V : bus.R;
      ps_d = '0;
    end else if (bus.E) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        step = 1'b1;
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end

    if (step) begin
      ovf_d = at_bound;
      if (!at_bound) begin
        q_d = bus.Up ? (q_q + 1'b1) : (q_q - 1'b1);
      end else if (SATURATE == 0) begin
        q_d = bus.Up ? '0 : MAX_V;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q_q   <= '0;
      ps_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ps_q  <= ps_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.TC  = at_bound;
  assign bus.Ovf = ovf_q;
endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four configurations share one stimulus stream,
// each tracked by an independent behavioural model feeding an expected queue.
module tb_mod_updown_counter;
  logic       clk;
  logic       resetn;
  logic       clear, l, e, up;
  logic [7:0] r;

  int n_checks;
  int n_errors;

  // Per-configuration parameters: A wrap 0..9, B saturate 0..12, C prescale 3, D full 3-bit.
  int cw[4];
  int cmax[4];
  int csat[4];
  int cps[4];

  // Model state
  int mq[4];
  int mps[4];
  int movf[4];

  logic [35:0] exp_q[$];

  mod_updown_counter_if #(.WIDTH(4)) a_if();
  mod_updown_counter_if #(.WIDTH(4)) b_if();
  mod_updown_counter_if #(.WIDTH(8)) c_if();
  mod_updown_counter_if #(.WIDTH(3)) d_if();

  mod_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(0), .PRESCALE(1)) u_a (
    .Clock(clk), .Resetn(resetn), .bus(a_if.slave));
  mod_updown_counter #(.WIDTH(4), .MAX(12), .SATURATE(1), .PRESCALE(1)) u_b (
    .Clock(clk), .Resetn(resetn), .bus(b_if.slave));
  mod_updown_counter #(.WIDTH(8), .MAX(255), .SATURATE(0), .PRESCALE(3)) u_c (
    .Clock(clk), .Resetn(resetn), .bus(c_if.slave));
  mod_updown_counter #(.WIDTH(3), .SATURATE(0), .PRESCALE(1)) u_d (
    .Clock(clk), .Resetn(resetn), .bus(d_if.slave));

  assign a_if.Clear = clear; assign a_if.L = l; assign a_if.E = e; assign a_if.Up = up;
  assign b_if.Clear = clear; assign b_if.L = l; assign b_if.E = e; assign b_if.Up = up;
  assign c_if.Clear = clear; assign c_if.L = l; assign c_if.E = e; assign c_if.Up = up;
  assign d_if.Clear = clear; assign d_if.L = l; assign d_if.E = e; assign d_if.Up = up;
  assign a_if.R = r[3:0];
  assign b_if.R = r[3:0];
  assign c_if.R = r;
  assign d_if.R = r[2:0];

  logic [7:0] obs_q[4];
  logic       obs_ovf[4];
  logic       obs_tc[4];
  assign obs_q[0] = {4'b0, a_if.Q};
  assign obs_q[1] = {4'b0, b_if.Q};
  assign obs_q[2] = c_if.Q;
  assign obs_q[3] = {5'b0, d_if.Q};
  assign obs_ovf[0] = a_if.Ovf; assign obs_tc[0] = a_if.TC;
  assign obs_ovf[1] = b_if.Ovf; assign obs_tc[1] = b_if.TC;
  assign obs_ovf[2] = c_if.Ovf; assign obs_tc[2] = c_if.TC;
  assign obs_ovf[3] = d_if.Ovf; assign obs_tc[3] = d_if.TC;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = 0; mps[i] = 0; movf[i] = 0;
    end
  endtask

  function automatic int model_tc(input int i);
    return up ? int'(mq[i] == cmax[i]) : int'(mq[i] == 0);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int  rv;
      bit  stp;
      stp = 0;
      rv  = int'(r) & ((1 << cw[i]) - 1);
      if (!resetn) begin
        mq[i] = 0; mps[i] = 0; movf[i] = 0;
      end else if (clear) begin
        mq[i] = 0; mps[i] = 0; movf[i] = 0;
      end else if (l) begin
        mq[i] = (rv > cmax[i]) ? cmax[i] : rv;
        mps[i] = 0; movf[i] = 0;
      end else if (e) begin
        if (mps[i] == cps[i] - 1) begin
          mps[i] = 0; stp = 1;
        end else begin
          mps[i]++;
        end
        movf[i] = 0;
      end else begin
        movf[i] = 0;
      end
      if (stp) begin
        if (up) begin
          if (mq[i] == cmax[i]) begin
            movf[i] = 1;
            if (csat[i] == 0) mq[i] = 0;
          end else mq[i]++;
        end else begin
          if (mq[i] == 0) begin
            movf[i] = 1;
            if (csat[i] == 0) mq[i] = cmax[i];
          end else mq[i]--;
        end
      end
    end
  endtask

  // Driver: apply one cycle of controls, predict, then compare after the edge.
  task automatic drive(input logic c_i, input logic l_i, input logic [7:0] r_i,
                       input logic e_i, input logic up_i);
    logic [35:0] item;
    clear = c_i; l = l_i; r = r_i; e = e_i; up = up_i;
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("tc%0d", i), 32'(obs_tc[i]), 32'(model_tc(i)));
    model_edge();
    item = '0;
    for (int i = 0; i < 4; i++) item[i*9 +: 9] = {movf[i][0], mq[i][7:0]};
    exp_q.push_back(item);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      item = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        check($sformatf("q%0d", i),   32'(obs_q[i]),   32'(item[i*9 +: 8]));
        check($sformatf("ovf%0d", i), 32'(obs_ovf[i]), 32'(item[i*9 + 8]));
      end
    end
  endtask

  int ovf_cnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    cw   = '{4, 4, 8, 3};
    cmax = '{9, 12, 255, 7};
    csat = '{0, 1, 0, 0};
    cps  = '{1, 1, 3, 1};
    resetn = 1'b0;
    clear = 1'b0; l = 1'b0; e = 1'b0; up = 1'b1; r = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_q%0d", i), 32'(obs_q[i]), 32'd0);
      check($sformatf("rst_ovf%0d", i), 32'(obs_ovf[i]), 32'd0);
    end

    // Wrap upward through 9 on A
    repeat (12) drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    check("a_wrap_up", 32'(obs_q[0]), 32'd2);

    // Down-wrap then direction flip
    drive(1'b0, 1'b1, 8'd2, 1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check("a_wrap_down", 32'(obs_q[0]), 32'd8);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    check("a_flip_q", 32'(obs_q[0]), 32'd9);
    check("a_flip_tc", 32'(obs_tc[0]), 32'd1);

    // Saturation and load clamp on B
    drive(1'b0, 1'b1, 8'd11, 1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    check("b_sat_q", 32'(obs_q[1]), 32'd12);
    check("b_sat_ovf", 32'(obs_ovf[1]), 32'd1);
    drive(1'b0, 1'b1, 8'd15, 1'b0, 1'b1);
    check("b_clamp", 32'(obs_q[1]), 32'd12);

    // Prescaler on C: hold with E low, restart on load
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    repeat (9) drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    check("c_ps_run", 32'(obs_q[2]), 32'd3);
    repeat (2) drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    repeat (5) drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    check("c_ps_hold", 32'(obs_q[2]), 32'd3);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    check("c_ps_resume", 32'(obs_q[2]), 32'd4);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 8'd20, 1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    check("c_ps_load_wait", 32'(obs_q[2]), 32'd20);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    check("c_ps_load_step", 32'(obs_q[2]), 32'd21);

    // Priority
    drive(1'b1, 1'b1, 8'd5, 1'b1, 1'b1);
    check("a_clear_wins", 32'(obs_q[0]), 32'd0);
    drive(1'b0, 1'b1, 8'd5, 1'b1, 1'b1);
    check("a_load_wins", 32'(obs_q[0]), 32'd5);
    drive(1'b0, 1'b1, 8'd7, 1'b0, 1'b1);

    // Asynchronous reset between edges
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("async_q%0d", i), 32'(obs_q[i]), 32'd0);
      check($sformatf("async_ovf%0d", i), 32'(obs_ovf[i]), 32'd0);
    end
    repeat (2) drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    resetn = 1'b1;
    repeat (4) drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);

    // Full-range 3-bit wrap on D
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    ovf_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
      ovf_cnt += int'(obs_ovf[3]);
    end
    check("d_ovf_count", 32'(ovf_cnt), 32'd2);
    check("d_final_q", 32'(obs_q[3]), 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 9) == 0),
            8'($urandom_range(0, 255)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
